// File: rtl/splitter_pkg.sv
// Shared types and constants for the ROM bit splitter: channel index, FSM state
// encoding and the round-robin channel search used for byte selection.
package splitter_pkg;

    typedef logic [1:0] chan_t;
    typedef logic       state_t;

    localparam state_t IDLE = 1'b0;
    localparam state_t SEND = 1'b1;

    localparam chan_t CH1 = 2'd0;

    localparam int BITS_PER_WORD      = 8;
    localparam int DEFAULT_BIT_CYCLES = 256;

    // Search for the next enabled channel starting at `from` (incl=1) or just
    // after it (incl=0); with incl=0 the last candidate is `from` itself, so a
    // lone enabled channel is reselected. Caller must check that any bit of en is set.
    function automatic chan_t next_chan(input logic [3:0] en, input chan_t from, input logic incl);
        chan_t step;
        chan_t cand;
        chan_t pick;
        step = {1'b0, ~incl};
        pick = from;
        for (int k = 3; k >= 0; k--) begin
            cand = from + chan_t'(k) + step;
            if (en[cand]) pick = cand;
        end
        return pick;
    endfunction

endpackage

// File: rtl/splitter_prescaler.sv
// Bit-period generator: counts 0..BIT_CYCLES-1 while running and pulses
// bit_tick on the last cycle of each serial bit; held at zero otherwise.
module splitter_prescaler #(
    parameter int BIT_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic [7:0] count,
    output logic       bit_tick
);

    localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

    assign bit_tick = run && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!run || bit_tick) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/rom_bit_splitter.sv
// Round-robin parallel-to-serial splitter: streams the enabled ROM words MSB
// first onto `out`, each bit held for BIT_CYCLES clocks, while holder is high.
module rom_bit_splitter
    import splitter_pkg::*;
#(
    parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES,
    parameter int DATA_W     = BITS_PER_WORD
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              sw1,
    input  logic              sw2,
    input  logic              sw3,
    input  logic              sw4,
    input  logic              holder,
    input  logic [DATA_W-1:0] rom1,
    input  logic [DATA_W-1:0] rom2,
    input  logic [DATA_W-1:0] rom3,
    input  logic [DATA_W-1:0] rom4,
    output logic              out,
    output logic [3:0]        count8,
    output logic [7:0]        count
);

    state_t            state;
    chan_t             ptr;
    logic [DATA_W-1:0] shreg;
    logic [2:0]        idx;
    logic              bit_tick;

    logic [3:0]        en;
    logic              any_en;
    chan_t             first_ch;
    chan_t             nxt_ch;
    logic [DATA_W-1:0] first_word;
    logic [DATA_W-1:0] nxt_word;

    assign en     = {sw4, sw3, sw2, sw1};
    assign any_en = |en;
    assign count8 = {1'b0, idx};

    splitter_prescaler #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_prescaler (
        .clk      (sysclk),
        .rst      (reset),
        .run      ((state == SEND) && holder),
        .count    (count),
        .bit_tick (bit_tick)
    );

    always_comb begin
        first_ch   = next_chan(en, CH1, 1'b1);
        nxt_ch     = next_chan(en, ptr, 1'b0);
        first_word = '0;
        nxt_word   = '0;
        case (first_ch)
            2'd0:    first_word = rom1;
            2'd1:    first_word = rom2;
            2'd2:    first_word = rom3;
            default: first_word = rom4;
        endcase
        case (nxt_ch)
            2'd0:    nxt_word = rom1;
            2'd1:    nxt_word = rom2;
            2'd2:    nxt_word = rom3;
            default: nxt_word = rom4;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= CH1;
            shreg <= '0;
            idx   <= '0;
            out   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out <= 1'b0;
                    idx <= '0;
                    ptr <= CH1;
                    if (holder && any_en) begin
                        ptr   <= first_ch;
                        shreg <= first_word;
                        out   <= first_word[DATA_W-1];
                        state <= SEND;
                    end
                end
                default: begin
                    if (!holder) begin
                        // Abort the byte in flight; a later start begins again at ch1.
                        state <= IDLE;
                        out   <= 1'b0;
                        idx   <= '0;
                        ptr   <= CH1;
                    end else if (bit_tick) begin
                        if (idx == 3'd7) begin
                            idx <= '0;
                            if (any_en) begin
                                ptr   <= nxt_ch;
                                shreg <= nxt_word;
                                out   <= nxt_word[DATA_W-1];
                            end else begin
                                state <= IDLE;
                                out   <= 1'b0;
                                ptr   <= CH1;
                            end
                        end else begin
                            shreg <= shreg << 1;
                            out   <= shreg[DATA_W-2];
                            idx   <= idx + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_bit_splitter.sv
// Directed bench for rom_bit_splitter: walks reset, single/multi-channel
// round-robin streaming, abort, idle-with-no-channel and async reset.
module tb_rom_bit_splitter;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       sw1, sw2, sw3, sw4;
    logic       holder;
    logic [7:0] rom1, rom2, rom3, rom4;
    logic       out;
    logic [3:0] count8;
    logic [7:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sysclk = ~sysclk;

    rom_bit_splitter dut (
        .sysclk (sysclk),
        .reset  (reset),
        .sw1    (sw1),
        .sw2    (sw2),
        .sw3    (sw3),
        .sw4    (sw4),
        .holder (holder),
        .rom1   (rom1),
        .rom2   (rom2),
        .rom3   (rom3),
        .rom4   (rom4),
        .out    (out),
        .count8 (count8),
        .count  (count)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle at the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out"}, 8'(out), 8'h00);
        chk({tag, "_count8"}, 8'(count8), 8'h00);
        chk({tag, "_count"}, count, 8'h00);
    endtask

    // Called just after the edge that loads byte b; returns just after the next byte load.
    task automatic check_byte(input string tag, input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_b%0d_out", tag, i), 8'(out), 8'(b[7-i]));
            chk($sformatf("%s_b%0d_count8", tag, i), 8'(count8), 8'(i));
            chk($sformatf("%s_b%0d_count", tag, i), count, 8'h00);
            step(255);
            chk($sformatf("%s_b%0d_out_hold", tag, i), 8'(out), 8'(b[7-i]));
            chk($sformatf("%s_b%0d_count_last", tag, i), count, 8'hFF);
            step(1);
        end
    endtask

    initial begin
        reset  = 1'b1;
        holder = 1'b1;
        sw1 = 1'b1; sw2 = 1'b0; sw3 = 1'b0; sw4 = 1'b0;
        rom1 = 8'h55; rom2 = 8'h00; rom3 = 8'h00; rom4 = 8'h00;

        step(3);
        chk_zero("reset_hold");

        reset = 1'b0;
        step(1);
        check_byte("ch1_a", 8'h55);
        check_byte("ch1_b", 8'h55);

        sw2 = 1'b1; rom2 = 8'hAA;
        check_byte("two_a", 8'h55);
        check_byte("two_b", 8'hAA);
        check_byte("two_c", 8'h55);

        sw3 = 1'b1; rom3 = 8'h3C;
        check_byte("three_a", 8'hAA);
        check_byte("three_b", 8'h3C);
        check_byte("three_c", 8'h55);
        check_byte("three_d", 8'hAA);

        sw4 = 1'b1; rom4 = 8'hC3; rom3 = 8'hFF;
        check_byte("four_a", 8'h3C);
        check_byte("four_b", 8'hC3);
        check_byte("four_c", 8'h55);

        step(3 * 256 + 10);
        chk("abort_pre_count8", 8'(count8), 8'h03);
        chk("abort_pre_count", count, 8'd10);
        chk("abort_pre_out", 8'(out), 8'h00);
        holder = 1'b0;
        step(1);
        chk_zero("abort_edge");
        step(4);
        chk_zero("abort_idle");
        holder = 1'b1;
        step(1);
        check_byte("restart", 8'h55);
        chk("restart_next_out", 8'(out), 8'h01);
        chk("restart_next_count8", 8'(count8), 8'h00);

        holder = 1'b0;
        sw1 = 1'b0; sw2 = 1'b0; sw3 = 1'b0; sw4 = 1'b0;
        step(1);
        holder = 1'b1;
        step(5);
        chk_zero("no_chan");
        sw3 = 1'b1; rom3 = 8'h96;
        step(1);
        check_byte("ch3_only", 8'h96);

        step(3 * 256 + 5);
        chk("async_pre_out", 8'(out), 8'h01);
        chk("async_pre_count8", 8'(count8), 8'h03);
        chk("async_pre_count", count, 8'd5);
        #2 reset = 1'b1;
        #1 chk_zero("async_reset");
        step(2);
        reset = 1'b0;
        holder = 1'b0;
        step(1);
        chk_zero("post_reset_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_bit_splitter.md
Name: rom_bit_splitter

Overview:
- Parallel-to-serial splitter.
- Holds four 8-bit ROM words, each gated by a channel switch (sw1..sw4).
- While `holder` is high, streams the bytes of enabled channels onto the single serial line `out`, MSB first, in round-robin channel order. Each bit is held for a fixed number of clock cycles.
- Sits between the ROM/constant pattern source and the output driver.
- Exposes bit-index and bit-period counters for debug and observation.

Parameters:
- BIT_CYCLES, 256, clock cycles each serial bit is held; legal range 2..256; `count` wraps at BIT_CYCLES-1.
- DATA_W, 8, ROM word width; fixed at 8 for this revision.

Ports:
- sysclk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- sw1  input  1  enable channel 1 (rom1).
- sw2  input  1  enable channel 2 (rom2).
- sw3  input  1  enable channel 3 (rom3).
- sw4  input  1  enable channel 4 (rom4).
- holder  input  1  run/hold: 1 = transmit, 0 = idle and clear.
- rom1  input  8  channel 1 data word.
- rom2  input  8  channel 2 data word.
- rom3  input  8  channel 3 data word.
- rom4  input  8  channel 4 data word.
- out  output  1  serial data, registered.
- count8  output  4  index of current bit within byte, 0..7; bit 3 is always 0.
- count  output  8  bit-period prescaler, 0..BIT_CYCLES-1.

Behaviour:
- Clock and reset: one clock (`sysclk`); `reset` is asynchronous and active-high.
- Reset values: out=0, count8=0, count=0, channel pointer=ch1, shift register=0, state=IDLE.
- State IDLE (entered from reset, or whenever holder=0):
  - out=0, count=0, count8=0, pointer=ch1.
  - On a rising edge with holder=1 and at least one switch set:
    - select the first enabled channel at or after the pointer (search ch1→ch2→ch3→ch4, wrapping);
    - load its rom word into the shift register;
    - drive out = word[7] on that same edge;
    - count=0, count8=0; go to SEND.
  - If holder=1 but no switch is set, remain in IDLE with outputs 0.
- State SEND:
  - Every edge, count increments.
  - When count==BIT_CYCLES-1: count←0; the shift register shifts left; out←next bit; count8 increments.
  - When count8==7 and count==BIT_CYCLES-1 (end of byte):
    - advance the pointer to the next enabled channel after the current one (wrapping; the same channel is reselected if it is the only one enabled);
    - load that rom word; out←its bit 7; count8←0.
    - If no switch is set at this point, go to IDLE (out=0).
- ROM word sampling: sampled only at the byte load; changes mid-byte do not affect the byte in flight.
- Switch sampling: sampled only at byte boundaries; mid-byte switch changes take effect at the next boundary.
- holder falling mid-byte: the byte is aborted on the next edge; go to IDLE with all outputs cleared. A later holder rise restarts from ch1.
- holder and reset together: reset dominates.
- Latency: first bit appears on `out` on the first rising edge where holder=1 is sampled.
- Byte duration: 8×BIT_CYCLES cycles, with no gap between consecutive bytes.

Decomposition:
- Shared package `splitter_pkg`:
  - chan_t: 2-bit channel index type;
  - state_t: IDLE/SEND;
  - constant BITS_PER_WORD=8;
  - default BIT_CYCLES.
- One sub-module, `splitter_prescaler`: the count/wrap generator. Outputs the `count` value and a one-cycle `bit_tick` pulse at BIT_CYCLES-1; it is cleared when not in SEND.
- Channel arbitration (next-enabled search) and the shift register stay in the top level.

Test Plan:
- Reset, single channel: assert reset with holder=1, sw1=1, rom1=0x55.
  - Required: out=0, count=0, count8=0 while reset is high.
  - After release: out sequence 0,1,0,1,0,1,0,1, each bit held 256 cycles; count8 steps 0..7; then repeats.
- Two channels: sw1=1, sw2=1, rom1=0x55, rom2=0xAA, holder=1.
  - Required: 0x55 serialized, immediately followed by 0xAA, then 0x55, alternating.
  - count8 returns to 0 at each byte start.
- Three channels: sw1, sw2, sw3 set, rom3=0x3C.
  - Required: byte order 0x55, 0xAA, 0x3C, wrapping.
  - Adding sw4 (rom4=0xC3) mid-byte inserts 0xC3 only after 0x3C completes.
- Abort: drop holder mid-byte (count8=3).
  - Required: next edge gives out=0, count=0, count8=0.
  - On re-raise, streaming restarts with ch1.
- No channel enabled: holder=1, all switches 0.
  - Required: out stays 0, counters stay 0.
  - Setting sw3 makes transmission start with rom3 on the next edge.
- Async reset mid-SEND: pulse reset between clock edges.
  - Required: outputs clear immediately, without waiting for a clock edge.
